// File: rtl/noc_port_arbitrator.sv
`default_nettype none
// ============================================================================
// Module      : noc_port_arbitrator
// Description : Output-port arbitrator for a NoC router. One round-robin VC
//               allocator per virtual channel plus one round-robin physical
//               port allocator; every grant is registered and held until the
//               owner frees it.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_port_arbitrator #(
  parameter int REQUESTERS = 5,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQUESTERS*CHANNELS-1:0] vc_request,
  output logic [REQUESTERS*CHANNELS-1:0] vc_grant,
  input  logic [REQUESTERS*CHANNELS-1:0] vc_free,
  input  logic [REQUESTERS*CHANNELS-1:0] port_request,
  output logic [REQUESTERS*CHANNELS-1:0] port_grant,
  input  logic [REQUESTERS*CHANNELS-1:0] port_free
);

  localparam int NUM_FLAT = REQUESTERS * CHANNELS;
  localparam int RW       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int PW       = (NUM_FLAT > 1) ? $clog2(NUM_FLAT) : 1;

  // Widened constants so the wrap arithmetic stays width-matched
  localparam logic [RW:0]   REQ_COUNT  = (RW+1)'(REQUESTERS);
  localparam logic [RW-1:0] LAST_REQ   = RW'(REQUESTERS - 1);
  localparam logic [PW:0]   FLAT_COUNT = (PW+1)'(NUM_FLAT);
  localparam logic [PW-1:0] LAST_FLAT  = PW'(NUM_FLAT - 1);

  typedef enum logic [0:0] {VC_IDLE = 1'b0, VC_BUSY = 1'b1} vc_state_t;
  typedef enum logic [0:0] {PORT_IDLE = 1'b0, PORT_LOCKED = 1'b1} port_state_t;

  // --------------------------------------------------------------------------
  // VC allocators: one independent FSM per channel
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    vc_state_t             state, state_nxt;
    logic [RW-1:0]         owner, owner_nxt;
    logic [RW-1:0]         ptr, ptr_nxt;
    logic [REQUESTERS-1:0] req, free, grant, grant_nxt;
    logic                  found;
    logic [RW:0]           sum;

    // Gather this channel's column out of the flat r*CHANNELS+c layout
    for (genvar r = 0; r < REQUESTERS; r++) begin : g_map
      assign req[r]                   = vc_request[r*CHANNELS+c];
      assign free[r]                  = vc_free[r*CHANNELS+c];
      assign vc_grant[r*CHANNELS+c]   = grant[r];
    end

    // Next state: round-robin pick from ptr while idle, release on owner free
    always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      found     = 1'b0;
      sum       = '0;
      case (state)
        VC_IDLE: begin
          for (int k = 0; k < REQUESTERS; k++) begin
            sum = {1'b0, ptr} + (RW+1)'(k);
            if (sum >= REQ_COUNT) sum = sum - REQ_COUNT;
            if (!found && req[sum[RW-1:0]]) begin
              found     = 1'b1;
              owner_nxt = sum[RW-1:0];
              state_nxt = VC_BUSY;
            end
          end
        end
        VC_BUSY: begin
          if (free[owner]) begin
            state_nxt = VC_IDLE;
            ptr_nxt   = (owner == LAST_REQ) ? '0 : owner + RW'(1);
          end
        end
        default: state_nxt = VC_IDLE;
      endcase
      for (int r = 0; r < REQUESTERS; r++) begin
        grant_nxt[r] = (state_nxt == VC_BUSY) && (owner_nxt == RW'(r));
      end
    end

    // State, owner, pointer and registered grant decode
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= VC_IDLE;
        owner <= '0;
        ptr   <= '0;
        grant <= '0;
      end else begin
        state <= state_nxt;
        owner <= owner_nxt;
        ptr   <= ptr_nxt;
        grant <= grant_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Physical port allocator: a pair competes only while it holds its VC
  // --------------------------------------------------------------------------
  port_state_t         port_state, port_state_nxt;
  logic [PW-1:0]       port_owner, port_owner_nxt;
  logic [PW-1:0]       port_ptr, port_ptr_nxt;
  logic [NUM_FLAT-1:0] eligible, port_grant_nxt;
  logic                port_found;
  logic [PW:0]         port_sum;

  assign eligible = port_request & vc_grant;

  // Next state: round-robin over flat indices while idle, release on owner free
  always_comb begin
    port_state_nxt = port_state;
    port_owner_nxt = port_owner;
    port_ptr_nxt   = port_ptr;
    port_found     = 1'b0;
    port_sum       = '0;
    case (port_state)
      PORT_IDLE: begin
        for (int k = 0; k < NUM_FLAT; k++) begin
          port_sum = {1'b0, port_ptr} + (PW+1)'(k);
          if (port_sum >= FLAT_COUNT) port_sum = port_sum - FLAT_COUNT;
          if (!port_found && eligible[port_sum[PW-1:0]]) begin
            port_found     = 1'b1;
            port_owner_nxt = port_sum[PW-1:0];
            port_state_nxt = PORT_LOCKED;
          end
        end
      end
      PORT_LOCKED: begin
        if (port_free[port_owner]) begin
          port_state_nxt = PORT_IDLE;
          port_ptr_nxt   = (port_owner == LAST_FLAT) ? '0 : port_owner + PW'(1);
        end
      end
      default: port_state_nxt = PORT_IDLE;
    endcase
    for (int i = 0; i < NUM_FLAT; i++) begin
      port_grant_nxt[i] = (port_state_nxt == PORT_LOCKED) && (port_owner_nxt == PW'(i));
    end
  end

  // Port state, owner, pointer and registered grant decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_state <= PORT_IDLE;
      port_owner <= '0;
      port_ptr   <= '0;
      port_grant <= '0;
    end else begin
      port_state <= port_state_nxt;
      port_owner <= port_owner_nxt;
      port_ptr   <= port_ptr_nxt;
      port_grant <= port_grant_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_port_arbitrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_port_arbitrator
// Description : Directed self-checking bench for noc_port_arbitrator
//               (REQUESTERS=5, CHANNELS=2, flat bit = r*2 + c).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_port_arbitrator;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] vc_request   = '0;
  logic [N-1:0] vc_free      = '0;
  logic [N-1:0] port_request = '0;
  logic [N-1:0] port_free    = '0;
  logic [N-1:0] vc_grant;
  logic [N-1:0] port_grant;

  int total = 0;
  int bad   = 0;

  noc_port_arbitrator #(.REQUESTERS(5), .CHANNELS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .vc_request   (vc_request),
    .vc_grant     (vc_grant),
    .vc_free      (vc_free),
    .port_request (port_request),
    .port_grant   (port_grant),
    .port_free    (port_free)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs are changed and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    vc_request   = '0;
    vc_free      = '0;
    port_request = '0;
    port_free    = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    chk("reset_vc", vc_grant, 10'h000);
    chk("reset_port", port_grant, 10'h000);

    // ---------------- single request r2/c0 (bit 4) ----------------
    vc_request = 10'h010;
    step();
    chk("single_grant", vc_grant, 10'h010);
    vc_request = 10'h000;
    step(); step(); step();
    chk("single_hold", vc_grant, 10'h010);
    vc_free = 10'h001;                    // non-owner free ignored
    step();
    chk("nonowner_free", vc_grant, 10'h010);
    vc_free = 10'h010;
    step();
    chk("single_release", vc_grant, 10'h000);
    vc_free = 10'h000;
    // pointer is now 3: r2 and r3 contend, r3 must win
    vc_request = 10'h050;
    step();
    chk("ptr_after_free", vc_grant, 10'h040);
    vc_request = 10'h010;
    vc_free    = 10'h040;
    step();
    chk("idle_gap", vc_grant, 10'h000);
    vc_free = 10'h000;
    step();
    chk("regrant_r2", vc_grant, 10'h010);

    // ---------------- fairness on channel 1: r0, r1, r4 ----------------
    do_reset();
    vc_request = 10'h20A;
    step();
    chk("rr_first_r0", vc_grant, 10'h002);
    step();
    chk("rr_hold_r0", vc_grant, 10'h002);
    vc_free = 10'h002;
    step();
    chk("rr_gap1", vc_grant, 10'h000);
    vc_free = 10'h000;
    step();
    chk("rr_second_r1", vc_grant, 10'h008);
    step();
    vc_free = 10'h008;
    step();
    chk("rr_gap2", vc_grant, 10'h000);
    vc_free = 10'h000;
    step();
    chk("rr_third_r4", vc_grant, 10'h200);
    step();
    vc_free = 10'h200;
    step();
    chk("rr_gap3", vc_grant, 10'h000);
    vc_free = 10'h000;
    step();
    chk("rr_wrap_r0", vc_grant, 10'h002);

    // ---------------- channel independence ----------------
    do_reset();
    vc_request = 10'h009;
    step();
    chk("chan_both", vc_grant, 10'h009);
    vc_request = 10'h000;
    vc_free    = 10'h001;
    step();
    chk("chan_free_c0", vc_grant, 10'h008);
    vc_free = 10'h000;

    // ---------------- port gating by VC grant ----------------
    do_reset();
    port_request = 10'h008;
    step();
    chk("gate_no_vc_a", port_grant, 10'h000);
    step();
    chk("gate_no_vc_b", port_grant, 10'h000);
    vc_request = 10'h008;
    step();
    chk("gate_vc_up", vc_grant, 10'h008);
    chk("gate_port_wait", port_grant, 10'h000);
    vc_request = 10'h000;
    step();
    chk("gate_port_up", port_grant, 10'h008);
    vc_free = 10'h008;                    // VC free alone keeps the port
    step();
    chk("vcfree_vc", vc_grant, 10'h000);
    chk("vcfree_port_held", port_grant, 10'h008);
    vc_free   = 10'h000;
    port_free = 10'h008;
    step();
    chk("port_release", port_grant, 10'h000);
    port_free    = 10'h000;
    port_request = 10'h000;

    // ---------------- port lock and pointer wrap ----------------
    do_reset();
    vc_request = 10'h201;
    step();
    chk("lock_vc", vc_grant, 10'h201);
    vc_request   = 10'h000;
    port_request = 10'h200;
    step();
    chk("lock_own9", port_grant, 10'h200);
    port_request = 10'h201;
    step(); step();
    chk("lock_hold9", port_grant, 10'h200);
    port_free = 10'h001;                  // non-owner port free ignored
    step();
    chk("lock_nonowner", port_grant, 10'h200);
    port_free = 10'h200;
    step();
    chk("lock_release", port_grant, 10'h000);
    port_free = 10'h000;
    step();
    chk("wrap_to_0", port_grant, 10'h001);
    // simultaneous port and VC free from owner index 0
    port_free = 10'h001;
    vc_free   = 10'h001;
    step();
    chk("dual_free_port", port_grant, 10'h000);
    chk("dual_free_vc", vc_grant, 10'h200);
    port_free = 10'h000;
    vc_free   = 10'h000;
    step();
    chk("after_dual_9", port_grant, 10'h200);

    // ---------------- asynchronous reset mid-operation ----------------
    do_reset();
    vc_request = 10'h010;
    step();
    vc_request = 10'h000;
    vc_free    = 10'h010;
    step();                               // channel 0 pointer now 3
    vc_free    = 10'h000;
    vc_request = 10'h010;
    step();
    port_request = 10'h010;
    step();
    chk("pre_rst_vc", vc_grant, 10'h010);
    step();
    chk("pre_rst_port", port_grant, 10'h010);
    rst = 1'b1;
    #2;
    chk("async_rst_vc", vc_grant, 10'h000);
    chk("async_rst_port", port_grant, 10'h000);
    vc_request   = 10'h041;               // r0 and r3 on channel 0
    port_request = 10'h001;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_vc_ptr0", vc_grant, 10'h001);
    step();
    chk("post_rst_port", port_grant, 10'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
